// File: rtl/reg_file_banked_if.sv
// Inport/outport valid-ready bundle between the control unit and reg_file_banked.
// master = control unit / requester side, slave = register file.
interface reg_file_banked_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_req;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_req;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_req, in_valid, in_data, out_req, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_req, in_valid, in_data, out_req, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/reg_file_banked.sv
// Banked register file: NREGS GPRs (r0 = accumulator with LIFO backup), flags, SP, RA, I/O handshakes.
// Optional macro RF_BYPASS_EN: reads return the value being written on the same edge.
module reg_file_banked #(
  parameter int unsigned     WIDTH        = 16,
  parameter int unsigned     NREGS        = 8,
  parameter int unsigned     SHADOW_DEPTH = 4,
  parameter logic [WIDTH-1:0] SP_RESET    = WIDTH'(16'hFFFF),
  localparam int unsigned    AW           = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             backup,
  input  logic             restore,
  output logic             shadow_full,
  output logic             shadow_empty,
  output logic             shadow_err,
  input  logic             page_wr,
  input  logic [3:0]       page_in,
  input  logic             compare_wr,
  input  logic [2:0]       compare_in,
  input  logic             int_wr,
  input  logic [8:0]       int_in,
  output logic [15:0]      flag_out,
  input  logic [1:0]       sp_op,
  input  logic [WIDTH-1:0] sp_in,
  output logic [WIDTH-1:0] sp_out,
  input  logic             ra_wr,
  input  logic [WIDTH-1:0] ra_in,
  output logic [WIDTH-1:0] ra_out,
  reg_file_banked_if.slave io
);

  localparam int unsigned CW    = $clog2(SHADOW_DEPTH + 1);
  localparam int unsigned IW    = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << IW;
  localparam int unsigned FW    = 16;

  typedef enum logic {S_IDLE, S_BUSY} out_state_e;

  logic [WIDTH-1:0] r_regs     [NREGS];
  logic [WIDTH-1:0] w_reg_next [NREGS];
  logic [WIDTH-1:0] r_shadow   [SLOTS];
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic [3:0]       r_page;
  logic [8:0]       r_int;
  logic [2:0]       r_cmp;
  logic [FW-1:0]    r_flag;
  logic [WIDTH-1:0] r_sp;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rd_a;
  logic [WIDTH-1:0] r_rd_b;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  out_state_e       r_state;
  out_state_e       w_state_nxt;
  logic [WIDTH-1:0] w_out_data_nxt;
  logic             w_out_valid_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_capture;
  logic             w_push;
  logic             w_pop;
  logic             w_err_set;
  logic [IW-1:0]    w_push_idx;
  logic [IW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  assign w_full     = (r_cnt == CW'(SHADOW_DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_capture  = io.in_req && io.in_valid;
  assign w_push     = backup && !restore && !w_full;
  assign w_pop      = restore && !backup && !w_empty;
  assign w_err_set  = (backup && restore) || (backup && w_full) || (restore && w_empty);
  assign w_push_idx = IW'(r_cnt);
  assign w_top_idx  = IW'(r_cnt - CW'(1));

  // Next register values; r0 arbitration: capture > restore > write. An attempted restore always claims r0.
  always_comb begin
    w_reg_next = r_regs;
    for (int i = 1; i < int'(NREGS); i++) begin
      if (wr_en && (wr_addr == AW'(i))) w_reg_next[i] = wr_data;
    end
    if (w_capture) begin
      w_reg_next[0] = io.in_data;
    end else if (restore) begin
      if (w_pop) w_reg_next[0] = r_shadow[w_top_idx];
    end else if (wr_en && (wr_addr == '0)) begin
      w_reg_next[0] = wr_data;
    end
  end

`ifdef RF_BYPASS_EN
  assign w_rd_a = w_reg_next[rd_addr_a];
  assign w_rd_b = w_reg_next[rd_addr_b];
`else
  assign w_rd_a = r_regs[rd_addr_a];
  assign w_rd_b = r_regs[rd_addr_b];
`endif

  // Outport handshake: capture r0 on request in IDLE, hold until the consumer accepts.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      S_IDLE: begin
        if (io.out_req) begin
          w_state_nxt     = S_BUSY;
          w_out_data_nxt  = r_regs[0];
          w_out_valid_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        if (io.out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
      for (int i = 0; i < int'(SLOTS); i++) r_shadow[i] <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_page      <= '0;
      r_int       <= '0;
      r_cmp       <= '0;
      r_flag      <= '0;
      r_sp        <= SP_RESET;
      r_ra        <= '0;
      r_rd_a      <= '0;
      r_rd_b      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_regs <= w_reg_next;
      if (w_push) begin
        r_shadow[w_push_idx] <= r_regs[0];
        r_cnt                <= r_cnt + CW'(1);
      end else if (w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_err_set) r_err <= 1'b1;
      if (page_wr)    r_page <= page_in;
      if (int_wr)     r_int  <= int_in;
      if (compare_wr) r_cmp  <= compare_in;
      r_flag <= {r_page, r_int, r_cmp};
      case (sp_op)
        2'b01:   r_sp <= sp_in;
        2'b10:   r_sp <= r_sp - WIDTH'(1);
        2'b11:   r_sp <= r_sp + WIDTH'(1);
        default: r_sp <= r_sp;
      endcase
      if (ra_wr) r_ra <= ra_in;
      r_rd_a      <= w_rd_a;
      r_rd_b      <= w_rd_b;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign rd_data_a    = r_rd_a;
  assign rd_data_b    = r_rd_b;
  assign shadow_full  = w_full;
  assign shadow_empty = w_empty;
  assign shadow_err   = r_err;
  assign flag_out     = r_flag;
  assign sp_out       = r_sp;
  assign ra_out       = r_ra;
  assign io.in_ready  = io.in_req;
  assign io.out_data  = r_out_data;
  assign io.out_valid = r_out_valid;

endmodule

// File: tb/tb_reg_file_banked.sv
// Directed self-checking bench for reg_file_banked (default parameters; honours RF_BYPASS_EN).
module tb_reg_file_banked;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr_a;
  logic [15:0] rd_data_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic        backup, restore;
  logic        shadow_full, shadow_empty, shadow_err;
  logic        page_wr;
  logic [3:0]  page_in;
  logic        compare_wr;
  logic [2:0]  compare_in;
  logic        int_wr;
  logic [8:0]  int_in;
  logic [15:0] flag_out;
  logic [1:0]  sp_op;
  logic [15:0] sp_in, sp_out;
  logic        ra_wr;
  logic [15:0] ra_in, ra_out;

  int errors = 0;
  int checks = 0;

  reg_file_banked_if #(.WIDTH(16)) io ();

  reg_file_banked dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .backup(backup), .restore(restore),
    .shadow_full(shadow_full), .shadow_empty(shadow_empty), .shadow_err(shadow_err),
    .page_wr(page_wr), .page_in(page_in),
    .compare_wr(compare_wr), .compare_in(compare_in),
    .int_wr(int_wr), .int_in(int_in), .flag_out(flag_out),
    .sp_op(sp_op), .sp_in(sp_in), .sp_out(sp_out),
    .ra_wr(ra_wr), .ra_in(ra_in), .ra_out(ra_out),
    .io(io)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    backup = 0; restore = 0; page_wr = 0; page_in = '0; compare_wr = 0; compare_in = '0;
    int_wr = 0; int_in = '0; sp_op = 2'b00; sp_in = '0; ra_wr = 0; ra_in = '0;
    io.in_req = 0; io.in_valid = 0; io.in_data = '0; io.out_req = 0; io.out_ready = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic write_r(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic read_a(input logic [2:0] a);
    rd_addr_a = a;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL reset_rd_a: got %h expected 0000", rd_data_a); end
    checks++; if (rd_data_b !== 16'h0000) begin errors++; $display("FAIL reset_rd_b: got %h expected 0000", rd_data_b); end
    checks++; if (sp_out !== 16'hFFFF) begin errors++; $display("FAIL reset_sp: got %h expected ffff", sp_out); end
    checks++; if (flag_out !== 16'h0000) begin errors++; $display("FAIL reset_flag: got %h expected 0000", flag_out); end
    checks++; if (ra_out !== 16'h0000) begin errors++; $display("FAIL reset_ra: got %h expected 0000", ra_out); end
    checks++; if (io.out_valid !== 1'b0 || io.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out: got valid=%b data=%h expected 0/0000", io.out_valid, io.out_data); end
    checks++; if ({shadow_full, shadow_empty, shadow_err} !== 3'b010) begin errors++; $display("FAIL reset_shadow: got full/empty/err=%b expected 010", {shadow_full, shadow_empty, shadow_err}); end
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", io.in_ready); end
  endtask

  task automatic test_read_write();
    logic [15:0] exp;
    do_reset();
    write_r(3'd3, 16'h1234);
    read_a(3'd3);
    checks++; if (rd_data_a !== 16'h1234) begin errors++; $display("FAIL rw_basic: got %h expected 1234", rd_data_a); end
`ifdef RF_BYPASS_EN
    exp = 16'hBEEF;
`else
    exp = 16'h1234;
`endif
    rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    write_r(3'd3, 16'hBEEF);
    checks++; if (rd_data_a !== exp) begin errors++; $display("FAIL rw_same_cycle: got %h expected %h", rd_data_a, exp); end
    tick();
    checks++; if (rd_data_b !== 16'hBEEF) begin errors++; $display("FAIL rw_next_read: got %h expected beef", rd_data_b); end
    rd_addr_b = 3'd5;
    tick();
    checks++; if (rd_data_b !== 16'h0000) begin errors++; $display("FAIL rw_other_reg: got %h expected 0000", rd_data_b); end
  endtask

  task automatic test_shadow_lifo();
    do_reset();
    write_r(3'd0, 16'h0001);
    backup = 1; tick(); backup = 0;
    write_r(3'd0, 16'h0002);
    backup = 1; tick(); backup = 0;
    write_r(3'd0, 16'h0003);
    restore = 1; tick(); restore = 0;
    read_a(3'd0);
    checks++; if (rd_data_a !== 16'h0002) begin errors++; $display("FAIL lifo_pop1: got %h expected 0002", rd_data_a); end
    restore = 1; tick(); restore = 0;
    read_a(3'd0);
    checks++; if (rd_data_a !== 16'h0001) begin errors++; $display("FAIL lifo_pop2: got %h expected 0001", rd_data_a); end
    checks++; if (shadow_empty !== 1'b1 || shadow_err !== 1'b0) begin errors++; $display("FAIL lifo_empty: got empty=%b err=%b expected 1/0", shadow_empty, shadow_err); end
    restore = 1; tick(); restore = 0;
    checks++; if (shadow_err !== 1'b1) begin errors++; $display("FAIL lifo_underflow_err: got %b expected 1", shadow_err); end
    read_a(3'd0);
    checks++; if (rd_data_a !== 16'h0001) begin errors++; $display("FAIL lifo_underflow_r0: got %h expected 0001", rd_data_a); end
  endtask

  task automatic test_shadow_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      backup = 1; wr_en = 1; wr_addr = 3'd0; wr_data = 16'h0010 + 16'(i);
      tick();
    end
    wr_en = 0;
    checks++; if (shadow_full !== 1'b1 || shadow_err !== 1'b0) begin errors++; $display("FAIL full_reached: got full=%b err=%b expected 1/0", shadow_full, shadow_err); end
    tick();
    backup = 0;
    checks++; if (shadow_full !== 1'b1 || shadow_err !== 1'b1) begin errors++; $display("FAIL full_overflow: got full=%b err=%b expected 1/1", shadow_full, shadow_err); end
    restore = 1; tick(); restore = 0;
    checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL full_after_pop: got %b expected 0", shadow_full); end
    read_a(3'd0);
    checks++; if (rd_data_a !== 16'h0012) begin errors++; $display("FAIL full_top: got %h expected 0012", rd_data_a); end
    restore = 1; tick(); tick(); restore = 0;
    checks++; if (shadow_empty !== 1'b0) begin errors++; $display("FAIL full_count_one: got empty=%b expected 0", shadow_empty); end
    restore = 1; tick(); restore = 0;
    checks++; if (shadow_empty !== 1'b1) begin errors++; $display("FAIL full_count_zero: got empty=%b expected 1", shadow_empty); end
    read_a(3'd0);
    checks++; if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL full_bottom: got %h expected 0000", rd_data_a); end
    do_reset();
    backup = 1; restore = 1; tick(); backup = 0; restore = 0;
    checks++; if (shadow_err !== 1'b1 || shadow_empty !== 1'b1) begin errors++; $display("FAIL conflict: got err=%b empty=%b expected 1/1", shadow_err, shadow_empty); end
  endtask

  task automatic test_sp_ra();
    do_reset();
    sp_op = 2'b11; tick();
    checks++; if (sp_out !== 16'h0000) begin errors++; $display("FAIL sp_pop_wrap: got %h expected 0000", sp_out); end
    sp_op = 2'b10; tick();
    checks++; if (sp_out !== 16'hFFFF) begin errors++; $display("FAIL sp_push_wrap: got %h expected ffff", sp_out); end
    tick();
    checks++; if (sp_out !== 16'hFFFE) begin errors++; $display("FAIL sp_push2: got %h expected fffe", sp_out); end
    sp_op = 2'b01; sp_in = 16'h8000; tick();
    sp_op = 2'b00; sp_in = 16'h1234; tick();
    checks++; if (sp_out !== 16'h8000) begin errors++; $display("FAIL sp_load_hold: got %h expected 8000", sp_out); end
    ra_wr = 1; ra_in = 16'hCAFE; tick();
    ra_wr = 0; ra_in = 16'h1111; tick();
    checks++; if (ra_out !== 16'hCAFE) begin errors++; $display("FAIL ra_write_hold: got %h expected cafe", ra_out); end
  endtask

  task automatic test_outport();
    do_reset();
    write_r(3'd0, 16'h00AA);
    io.out_req = 1; tick(); io.out_req = 0;
    for (int i = 0; i < 3; i++) begin
      io.out_req = 1; wr_en = 1; wr_addr = 3'd0; wr_data = 16'h00BB + 16'(i);
      tick();
      checks++; if (io.out_valid !== 1'b1 || io.out_data !== 16'h00AA) begin errors++; $display("FAIL out_hold%0d: got valid=%b data=%h expected 1/00aa", i, io.out_valid, io.out_data); end
    end
    io.out_req = 0; wr_en = 0;
    io.out_ready = 1; tick();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL out_accept: got %b expected 0", io.out_valid); end
    tick();
    io.out_ready = 0;
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL out_ready_idle: got %b expected 0", io.out_valid); end
    io.out_req = 1; tick(); io.out_req = 0;
    checks++; if (io.out_valid !== 1'b1 || io.out_data !== 16'h00BD) begin errors++; $display("FAIL out_second: got valid=%b data=%h expected 1/00bd", io.out_valid, io.out_data); end
  endtask

  task automatic test_priority_flags();
    do_reset();
    write_r(3'd0, 16'h0042);
    backup = 1; tick(); backup = 0;
    io.in_req = 1; io.in_valid = 1; io.in_data = 16'h5555;
    restore = 1; wr_en = 1; wr_addr = 3'd0; wr_data = 16'h7777;
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL in_ready: got %b expected 1", io.in_ready); end
    tick();
    io.in_valid = 0; restore = 0; wr_en = 0; io.in_data = 16'h1234;
    checks++; if (shadow_empty !== 1'b1 || shadow_err !== 1'b0) begin errors++; $display("FAIL prio_pop: got empty=%b err=%b expected 1/0", shadow_empty, shadow_err); end
    read_a(3'd0);
    io.in_req = 0;
    checks++; if (rd_data_a !== 16'h5555) begin errors++; $display("FAIL prio_capture: got %h expected 5555", rd_data_a); end
    tick();
    checks++; if (rd_data_a !== 16'h5555) begin errors++; $display("FAIL in_no_valid: got %h expected 5555", rd_data_a); end
    page_wr = 1; page_in = 4'hA; int_wr = 1; int_in = 9'h1FF; compare_wr = 1; compare_in = 3'h5;
    tick();
    page_wr = 0; int_wr = 0; compare_wr = 0;
    checks++; if (flag_out !== 16'h0000) begin errors++; $display("FAIL flag_latency: got %h expected 0000", flag_out); end
    tick();
    checks++; if (flag_out !== 16'hAFFD) begin errors++; $display("FAIL flag_value: got %h expected affd", flag_out); end
    page_wr = 1; page_in = 4'h3; tick(); page_wr = 0; tick();
    checks++; if (flag_out !== 16'h3FFD) begin errors++; $display("FAIL flag_page_only: got %h expected 3ffd", flag_out); end
  endtask

  initial begin
    set_idle();
    rst = 1;
    test_reset();
    test_read_write();
    test_shadow_lifo();
    test_shadow_full();
    test_sp_ra();
    test_outport();
    test_priority_flags();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
